// File: rtl/fifo_mem_pkg.sv
// Shared types and sizing helpers for the fifo_mem_gen2 family.
package fifo_mem_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } fifo_rd_mode_e;

  // Occupancy/pointer width: index bits plus one wrap bit.
  function automatic int cnt_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit FIFO pointer: the index rolls over at DEPTH and carries into the wrap bit.
module fifo_ptr_ctrl #(
  parameter int PTR_W = 4
) (
  input  logic             clk_in,
  input  logic             areset_b,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  // DEPTH is a power of two, so a plain binary increment wraps the index and toggles the MSB.
  always_ff @(posedge clk_in) begin
    if (!areset_b) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_mem_gen2.sv
// Synchronous FIFO with selectable registered or first-word-fall-through read,
// occupancy/almost flags and sticky overflow/underflow indicators.
module fifo_mem_gen2
  import fifo_mem_pkg::*;
#(
  parameter int            DATA_WIDTH = 32,
  parameter int            DEPTH      = 8,
  parameter fifo_rd_mode_e READ_MODE  = RD_STD,
  parameter int            AF_LEVEL   = DEPTH - 2,
  parameter int            AE_LEVEL   = 2,
  localparam int           CNT_W      = cnt_w_f(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full_ind,
  output logic                  empty_ind,
  output logic                  almost_full_ind,
  output logic                  almost_empty_ind,
  output logic                  overflow_ind,
  output logic                  underflow_ind,
  input  logic                  clr_err
);

  localparam int AW = CNT_W - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_mem_gen2: DEPTH must be a power of two and at least 2");
  end

  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign empty_ind        = (wr_ptr == rd_ptr);
  assign full_ind         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count            = wr_ptr - rd_ptr;
  assign almost_full_ind  = (int'(count) >= AF_LEVEL);
  assign almost_empty_ind = (int'(count) <= AE_LEVEL);
  assign wr_ready         = ~full_ind;

  // Reset overrides any concurrent transfer; full/empty refusal has no bypass path.
  assign wr_fire = areset_b & wr_valid & ~full_ind;
  assign rd_fire = areset_b & rd_ready & ~empty_ind;
  assign head    = mem[rd_ptr[AW-1:0]];

  fifo_ptr_ctrl #(.PTR_W(CNT_W)) u_wr_ptr (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .en       (wr_fire),
    .ptr      (wr_ptr)
  );

  fifo_ptr_ctrl #(.PTR_W(CNT_W)) u_rd_ptr (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .en       (rd_fire),
    .ptr      (rd_ptr)
  );

  always_ff @(posedge clk_in) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk_in) begin
    if (!areset_b) begin
      overflow_ind  <= 1'b0;
      underflow_ind <= 1'b0;
    end else begin
      if (wr_valid && full_ind) begin
        overflow_ind <= 1'b1;
      end else if (clr_err) begin
        overflow_ind <= 1'b0;
      end
      if (rd_ready && empty_ind) begin
        underflow_ind <= 1'b1;
      end else if (clr_err) begin
        underflow_ind <= 1'b0;
      end
    end
  end

  if (READ_MODE == RD_FWFT) begin : g_fwft
    assign rd_valid = ~empty_ind;
    assign rd_data  = empty_ind ? '0 : head;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // Stage p1: registered read, data held between pops.
    always_ff @(posedge clk_in) begin
      if (!areset_b) begin
        rd_data_p1 <= '0;
        vld_p1     <= 1'b0;
      end else begin
        vld_p1 <= rd_fire;
        if (rd_fire) begin
          rd_data_p1 <= head;
        end
      end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = rd_data_p1;
  end

endmodule
